// File: rtl/mist1032isa_mem_pkg.sv
// Shared definitions for the load/store-to-memory bridge: order codes, request
// and tag layouts, byte-lane mask generation, store replication and read extraction.
package mist1032isa_mem_pkg;

  localparam logic [1:0] ORDER_BYTE = 2'b00;
  localparam logic [1:0] ORDER_HALF = 2'b01;
  localparam logic [1:0] ORDER_WORD = 2'b10;
  localparam logic [1:0] ORDER_NOP  = 2'b11;

  localparam int TAG_W = 5;

  typedef struct packed {
    logic [1:0]  order;
    logic        rw;
    logic [25:0] addr;
    logic [31:0] data;
  } req_t;

  // Outstanding-read tag: byte offset inside the 64-bit beat plus access size.
  typedef struct packed {
    logic [2:0] addr;
    logic [1:0] order;
  } tag_t;

  localparam req_t REQ_RESET = '{order: ORDER_NOP, rw: 1'b0, addr: 26'h0, data: 32'h0};

  function automatic logic [3:0] gen_mask(input logic [1:0] order, input logic [1:0] addr);
    case (order)
      ORDER_BYTE: gen_mask = 4'b0001 << addr;
      ORDER_HALF: gen_mask = addr[1] ? 4'b1100 : 4'b0011;
      ORDER_WORD: gen_mask = 4'b1111;
      default:    gen_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] rep_data(input logic [1:0] order, input logic [31:0] data);
    case (order)
      ORDER_BYTE: rep_data = {4{data[7:0]}};
      ORDER_HALF: rep_data = {2{data[15:0]}};
      ORDER_WORD: rep_data = data;
      default:    rep_data = 32'h0;
    endcase
  endfunction

  // Misaligned low address bits are simply dropped by the shift granularity.
  function automatic logic [31:0] extract_read(input tag_t tag, input logic [63:0] beat);
    logic [31:0] half;
    half = tag.addr[2] ? beat[63:32] : beat[31:0];
    case (tag.order)
      ORDER_BYTE: extract_read = (half >> {tag.addr[1:0], 3'b000}) & 32'h0000_00FF;
      ORDER_HALF: extract_read = (half >> {tag.addr[1], 4'b0000}) & 32'h0000_FFFF;
      default:    extract_read = half;
    endcase
  endfunction

endpackage

// File: rtl/mist1032isa_sync_fifo.sv
// Small synchronous FIFO with wrap-bit pointers; depth must be 2**P_DEPTH_N.
// Push at full is honoured when a pop frees a slot in the same cycle.
module mist1032isa_sync_fifo #(
  parameter int P_N       = 16,
  parameter int P_DEPTH   = 4,
  parameter int P_DEPTH_N = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push,
  input  logic [P_N-1:0] push_data,
  output logic           full,
  input  logic           pop,
  output logic [P_N-1:0] pop_data,
  output logic           empty
);

  logic [P_N-1:0]     mem [P_DEPTH];
  logic [P_DEPTH_N:0] wr_ptr;
  logic [P_DEPTH_N:0] rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[P_DEPTH_N] != rd_ptr[P_DEPTH_N]) &&
                    (wr_ptr[P_DEPTH_N-1:0] == rd_ptr[P_DEPTH_N-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[P_DEPTH_N-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < P_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[P_DEPTH_N-1:0]] <= push_data;
        wr_ptr                     <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/mist1032isa_mem_access_bridge.sv
// Load/store unit to 64-bit memory port bridge: one registered request, byte-masked
// issue with replicated store data, in-order read tags and an aligned result register.
module mist1032isa_mem_access_bridge
  import mist1032isa_mem_pkg::*;
#(
  parameter int P_TAG_DEPTH   = 4,
  parameter int P_TAG_DEPTH_N = 2
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iREQ,
  output logic        oLOCK,
  input  logic [1:0]  iORDER,
  input  logic        iRW,
  input  logic [25:0] iADDR,
  input  logic [31:0] iDATA,
  output logic        oVALID,
  input  logic        iLOCK,
  output logic [31:0] oDATA,
  output logic        oMEMORY_REQ,
  input  logic        iMEMORY_LOCK,
  output logic [1:0]  oMEMORY_ORDER,
  output logic [3:0]  oMEMORY_MASK,
  output logic        oMEMORY_RW,
  output logic [25:0] oMEMORY_ADDR,
  output logic [31:0] oMEMORY_DATA,
  input  logic        iMEMORY_VALID,
  output logic        oMEMORY_LOCK,
  input  logic [63:0] iMEMORY_DATA
);

  req_t        b_req;
  logic        b_req_valid;
  logic        b_out_valid;
  logic [31:0] b_out_data;

  logic        req_noop;
  logic        issue;
  logic        accept;
  logic        tag_push;
  logic        tag_pop;
  logic        tag_full;
  logic        tag_empty;
  logic        beat_take;
  tag_t        tag_head;

  // A no-op leaves the register without touching memory or the tag FIFO.
  assign req_noop = (b_req.order == ORDER_NOP);
  assign issue    = b_req_valid &&
                    (req_noop || (!iMEMORY_LOCK && (b_req.rw || !tag_full)));
  assign oLOCK    = b_req_valid && !issue;
  assign accept   = iREQ && !oLOCK;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      b_req_valid <= 1'b0;
      b_req       <= REQ_RESET;
    end else if (accept) begin
      b_req_valid <= 1'b1;
      b_req       <= '{order: iORDER, rw: iRW, addr: iADDR, data: iDATA};
    end else if (issue) begin
      b_req_valid <= 1'b0;
    end
  end

  assign oMEMORY_REQ   = issue && !req_noop;
  assign oMEMORY_ORDER = b_req.order;
  assign oMEMORY_MASK  = gen_mask(b_req.order, b_req.addr[1:0]);
  assign oMEMORY_RW    = b_req.rw;
  assign oMEMORY_ADDR  = b_req.addr;
  assign oMEMORY_DATA  = rep_data(b_req.order, b_req.data);

  assign tag_push  = oMEMORY_REQ && !b_req.rw;
  assign beat_take = iMEMORY_VALID && !oMEMORY_LOCK;
  assign tag_pop   = beat_take && !tag_empty;

  mist1032isa_sync_fifo #(TAG_W, P_TAG_DEPTH, P_TAG_DEPTH_N) u_tag_fifo (
    .clk       (iCLOCK),
    .rst_n     (inRESET),
    .push      (tag_push),
    .push_data ({b_req.addr[2:0], b_req.order}),
    .full      (tag_full),
    .pop       (tag_pop),
    .pop_data  (tag_head),
    .empty     (tag_empty)
  );

  // Result holds while the core stalls; memory is told to hold its next beat meanwhile.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      b_out_valid <= 1'b0;
      b_out_data  <= 32'h0;
    end else if (tag_pop) begin
      b_out_valid <= 1'b1;
      b_out_data  <= extract_read(tag_head, iMEMORY_DATA);
    end else if (!iLOCK) begin
      b_out_valid <= 1'b0;
    end
  end

  assign oVALID       = b_out_valid;
  assign oDATA        = b_out_data;
  assign oMEMORY_LOCK = b_out_valid && iLOCK;

`ifndef SYNTHESIS
  always_ff @(posedge iCLOCK) begin
    if (inRESET && beat_take && tag_empty)
      $display("%m: read beat with no outstanding tag, discarded (t=%0t)", $time);
  end
`endif

endmodule
